// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared 3x3 window geometry and slot indices for the median/rank filter
package win_pkg;

    localparam int WIN_DIM    = 3;
    localparam int WIN_TAPS   = WIN_DIM * WIN_DIM;
    localparam int CENTRE_IDX = 4;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Slot k = 3*r + c; r=0 is the oldest row, c=0 the oldest column.
    localparam int SLOT_TL = 0;
    localparam int SLOT_TC = 1;
    localparam int SLOT_TR = 2;
    localparam int SLOT_ML = 3;
    localparam int SLOT_MC = CENTRE_IDX;
    localparam int SLOT_MR = 5;
    localparam int SLOT_BL = 6;
    localparam int SLOT_BC = 7;
    localparam int SLOT_BR = 8;

    function automatic int slot_idx(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port line store, combinational read, read-before-write
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are never reset; the window gating hides stale entries.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/win3x3_gen.sv
// rtl/win3x3_gen.sv - raster stream to 3x3 window generator; optional BORDER_FLAG_EN emits border windows too
module win3x3_gen
    import win_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          in_pix,
    input  logic                           in_valid,
    input  logic                           in_sof,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] out_win,
    output logic                           out_valid,
    output logic                           out_eof
`ifdef BORDER_FLAG_EN
    ,
    output logic                           out_border
`endif
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] MIN_COL  = COL_W'(WIN_DIM - 1);
    localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(WIN_DIM - 1);

    logic [COL_W-1:0]               col;
    logic [ROW_W-1:0]               row;
    logic [COL_W-1:0]               cur_col;
    logic [ROW_W-1:0]               cur_row;
    logic [DATA_WIDTH-1:0]          lb0_rd;
    logic [DATA_WIDTH-1:0]          lb1_rd;
    logic [WIN_TAPS*DATA_WIDTH-1:0] win_q;
    logic [WIN_TAPS*DATA_WIDTH-1:0] win_d;
    logic                           full;
    logic                           last;

    // A start-of-frame pixel resyncs to (0,0) whatever the counters say.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;
    assign full    = (cur_col >= MIN_COL) && (cur_row >= MIN_ROW);
    assign last    = (cur_col == LAST_COL) && (cur_row == LAST_ROW);

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (in_pix),
        .rdata (lb0_rd)
    );

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
                win_d[slot_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] =
                    win_q[slot_idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_d[SLOT_TR*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
        win_d[SLOT_MR*DATA_WIDTH +: DATA_WIDTH] = lb0_rd;
        win_d[SLOT_BR*DATA_WIDTH +: DATA_WIDTH] = in_pix;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            win_q     <= '0;
            out_win   <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
`ifdef BORDER_FLAG_EN
            out_border <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            if (in_valid) begin
                win_q <= win_d;
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
`ifdef BORDER_FLAG_EN
                out_valid  <= 1'b1;
                out_eof    <= last;
                out_border <= !full;
                out_win    <= full ? win_d : '0;
`else
                if (full) begin
                    out_valid <= 1'b1;
                    out_eof   <= last;
                    out_win   <= win_d;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_win3x3_gen.sv
// tb/tb_win3x3_gen.sv - table-driven scoreboard bench for win3x3_gen on a 4x3 image
module tb_win3x3_gen;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int WB   = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_pix = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [WB-1:0] out_win;
    logic          out_valid;
    logic          out_eof;
`ifdef BORDER_FLAG_EN
    logic          out_border;
`endif

    win3x3_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_W      (10),
        .ROW_W      (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_win   (out_win),
        .out_valid (out_valid),
        .out_eof   (out_eof)
`ifdef BORDER_FLAG_EN
        ,
        .out_border (out_border)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pix;
        logic          exp_valid;
        logic          exp_eof;
        logic          exp_border;
        logic [WB-1:0] exp_win;
    } vec_t;

    typedef struct {
        logic [WB-1:0] win;
        logic          eof;
        logic          border;
        int            cyc;
    } exp_t;

    vec_t tbl [NPIX];
    exp_t sbq [$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got=%h want=%h", name, act, req);
    endtask

    function automatic logic [WB-1:0] mkwin(input int base, input int v [9]);
        logic [WB-1:0] w;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(base + v[k]);
        return w;
    endfunction

    task automatic send_pix(input int idx, input int base, input logic sof);
        exp_t e;
        @(negedge clk);
        in_pix   = DW'(base + idx);
        in_valid = 1'b1;
        in_sof   = sof;
        if (tbl[idx].exp_valid) begin
            e.win = tbl[idx].exp_win;
            if (!tbl[idx].exp_border) begin
                for (int k = 0; k < 9; k++) e.win[k*DW +: DW] = e.win[k*DW +: DW] + DW'(base);
            end
            e.eof    = tbl[idx].exp_eof;
            e.border = tbl[idx].exp_border;
            e.cyc    = cyc + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic sof_noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = sof_noise;
            in_pix   = DW'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, WB'(out_valid), WB'(0));
        check({tag, "_eof"}, WB'(out_eof), WB'(0));
        check({tag, "_win"}, out_win, WB'(0));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, WB'(sbq.size()), WB'(0));
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got=%h want=no pulse", out_win);
            end else begin
                mon_e = sbq.pop_front();
                check("win", out_win, mon_e.win);
                check("eof", WB'(out_eof), WB'(mon_e.eof));
                check("latency", WB'(cyc), WB'(mon_e.cyc));
`ifdef BORDER_FLAG_EN
                check("border", WB'(out_border), WB'(mon_e.border));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            logic full;
            full            = ((i % W) >= 2) && ((i / W) >= 2);
            tbl[i].pix      = DW'(i);
            tbl[i].exp_eof  = (i == NPIX - 1);
            tbl[i].exp_win  = '0;
`ifdef BORDER_FLAG_EN
            tbl[i].exp_valid  = 1'b1;
            tbl[i].exp_border = !full;
`else
            tbl[i].exp_valid  = full;
            tbl[i].exp_border = 1'b0;
`endif
        end
        tbl[10].exp_win = mkwin(0, '{0, 1, 2, 4, 5, 6, 8, 9, 10});
        tbl[11].exp_win = mkwin(0, '{1, 2, 3, 5, 6, 7, 9, 10, 11});

        // Reset held with active inputs, then released with idle inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_sof   = ~i[0];
            in_pix   = DW'(8'hA0 + i);
            check_quiet("in_reset");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        idle(3, 1'b0);
        check_quiet("after_release");

        // Back-to-back frame; the whole stimulus table applied in order.
        for (int i = 0; i < NPIX; i++) send_pix(i, 0, i == 0);
        idle(2, 1'b0);
        drain("b2b");

        // Same frame with random idle gaps, some carrying a stray sof.
        for (int i = 0; i < NPIX; i++) begin
            send_pix(i, 0, i == 0);
            idle($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        idle(2, 1'b0);
        drain("gaps");

        // Aborted frame followed by a resync into a frame offset by 100.
        for (int i = 0; i < 6; i++) send_pix(i, 0, i == 0);
        for (int i = 0; i < NPIX; i++) send_pix(i, 100, i == 0);
        idle(2, 1'b0);
        drain("resync");

        // Asynchronous reset mid-frame, then a frame without sof relies on cleared counters.
        for (int i = 0; i < 10; i++) send_pix(i, 0, i == 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sbq.delete();
        #1;
        check_quiet("async_rst");
        in_valid = 1'b0;
        in_sof   = 1'b0;
        idle(2, 1'b0);
        rst = 1'b1;
        idle(1, 1'b0);
        for (int i = 0; i < NPIX; i++) send_pix(i, 0, 1'b0);
        idle(2, 1'b0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
